// File: rtl/palette_mapper.sv
// Two-stage pixel colour pipeline for up to eight ball channels, with a writable
// palette and per-frame overlap (collision) statistics.
module palette_mapper #(
  parameter int NUM_BALLS = 4,
  parameter int COLOR_W = 8,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = 24'h000000
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [NUM_BALLS-1:0]   is_ball,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   blank_n,
  input  logic [1:0]             mode,
  input  logic                   pal_we,
  input  logic [2:0]             pal_addr,
  input  logic [3*COLOR_W-1:0]   pal_data,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B,
  output logic                   collision_last,
  output logic [15:0]            collision_count
);

  localparam int IDW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam int CW  = 3 * COLOR_W;
  localparam int SW  = COLOR_W + 3;

  // Default palette entries are defined as 8-bit channels; keep their MSBs at other widths.
  function automatic logic [COLOR_W-1:0] widen_channel(input logic [7:0] c8);
    logic [COLOR_W+7:0] t;
    t = {c8, {COLOR_W{1'b0}}};
    return t[COLOR_W+7 -: COLOR_W];
  endfunction

  function automatic logic [CW-1:0] default_entry(input logic [3:0] idx);
    logic [CW-1:0] e;
    case (idx)
      4'd0:    e = {widen_channel(8'hFF), widen_channel(8'h99), widen_channel(8'h99)};
      4'd1:    e = {widen_channel(8'h99), widen_channel(8'hFF), widen_channel(8'h99)};
      4'd2:    e = {widen_channel(8'hCC), widen_channel(8'hFF), widen_channel(8'hFF)};
      4'd3:    e = {widen_channel(8'hFF), widen_channel(8'hFF), widen_channel(8'h99)};
      default: e = {CW{1'b1}};
    endcase
    return e;
  endfunction

  function automatic logic [COLOR_W-1:0] sat_channel(input logic [SW-1:0] s);
    return (|s[SW-1:COLOR_W]) ? {COLOR_W{1'b1}} : s[COLOR_W-1:0];
  endfunction

  logic [CW-1:0]        palette_r [NUM_BALLS];

  logic [NUM_BALLS-1:0] s1_ball_r;
  logic                 s1_blank_n_r;
  logic [9:0]           s1_x_r;
  logic [9:0]           s1_y_r;
  logic [1:0]           s1_mode_r;
  logic                 s1_hit_r;
  logic [IDW-1:0]       s1_id_r;
  logic                 s1_multi_r;

  logic                 hit_s;
  logic [IDW-1:0]       id_s;
  logic [3:0]           ones_s;
  logic                 multi_s;

  logic [CW-1:0]        entry_s;
  logic [SW-1:0]        sum_r_s;
  logic [SW-1:0]        sum_g_s;
  logic [SW-1:0]        sum_b_s;
  logic [CW-1:0]        rgb_s;
  logic                 boundary_s;
  logic                 contrib_s;
  logic                 addr_ok_s;

  logic                 run_flag_r;
  logic [15:0]          run_count_r;

  // Stage-1 decode: any hit, lowest-index hit, and two-or-more hits.
  always_comb begin
    id_s   = {IDW{1'b0}};
    ones_s = 4'd0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      id_s   = is_ball[i] ? IDW'(i) : id_s;
      ones_s = ones_s + {3'b000, is_ball[i]};
    end
    hit_s   = |is_ball;
    multi_s = (ones_s >= 4'd2);
  end

  // Stage-2 colour selection from the registered pixel and the current palette contents.
  always_comb begin
    sum_r_s = {SW{1'b0}};
    sum_g_s = {SW{1'b0}};
    sum_b_s = {SW{1'b0}};
    for (int i = 0; i < NUM_BALLS; i++) begin
      sum_r_s = sum_r_s + (s1_ball_r[i] ? {3'b000, palette_r[i][CW-1 -: COLOR_W]} : {SW{1'b0}});
      sum_g_s = sum_g_s + (s1_ball_r[i] ? {3'b000, palette_r[i][2*COLOR_W-1 -: COLOR_W]} : {SW{1'b0}});
      sum_b_s = sum_b_s + (s1_ball_r[i] ? {3'b000, palette_r[i][COLOR_W-1:0]} : {SW{1'b0}});
    end
    entry_s = palette_r[s1_id_r];
    if (!s1_blank_n_r) begin
      rgb_s = {CW{1'b0}};
    end else if (!s1_hit_r) begin
      rgb_s = BG_COLOR;
    end else begin
      case (s1_mode_r)
        2'd0:    rgb_s = entry_s;
        2'd1:    rgb_s = s1_multi_r ? {CW{1'b1}} : entry_s;
        2'd2:    rgb_s = {sat_channel(sum_r_s), sat_channel(sum_g_s), sat_channel(sum_b_s)};
        2'd3:    rgb_s = entry_s;
        default: rgb_s = entry_s;
      endcase
    end
  end

  // Frame boundary and collision contribution of the stage-2 pixel; palette address check.
  always_comb begin
    boundary_s = (s1_x_r == 10'd0) && (s1_y_r == 10'd0);
    contrib_s  = s1_multi_r && s1_blank_n_r;
    addr_ok_s  = ({29'd0, pal_addr} < 32'(NUM_BALLS));
  end

  // Stage-1 pipeline registers; the reset state is a blanked, empty pixel.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_ball_r    <= {NUM_BALLS{1'b0}};
      s1_blank_n_r <= 1'b0;
      s1_x_r       <= 10'd0;
      s1_y_r       <= 10'd0;
      s1_mode_r    <= 2'd0;
      s1_hit_r     <= 1'b0;
      s1_id_r      <= {IDW{1'b0}};
      s1_multi_r   <= 1'b0;
    end else begin
      s1_ball_r    <= is_ball;
      s1_blank_n_r <= blank_n;
      s1_x_r       <= DrawX;
      s1_y_r       <= DrawY;
      s1_mode_r    <= mode;
      s1_hit_r     <= hit_s;
      s1_id_r      <= id_s;
      s1_multi_r   <= multi_s;
    end
  end

  // Stage-2 registered colour output.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      {VGA_R, VGA_G, VGA_B} <= {CW{1'b0}};
    end else begin
      {VGA_R, VGA_G, VGA_B} <= rgb_s;
    end
  end

  // Palette storage; a write lands at the edge, so the same-cycle lookup still sees the old entry.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        palette_r[i] <= default_entry(4'(i));
      end
    end else if (pal_we && addr_ok_s) begin
      palette_r[pal_addr[IDW-1:0]] <= pal_data;
    end
  end

  // Collision statistics; the (0,0) pixel closes the old frame and opens the new one.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      run_flag_r      <= 1'b0;
      run_count_r     <= 16'd0;
      collision_last  <= 1'b0;
      collision_count <= 16'd0;
    end else if (boundary_s) begin
      collision_last  <= run_flag_r;
      collision_count <= run_count_r;
      run_flag_r      <= contrib_s;
      run_count_r     <= {15'd0, contrib_s};
    end else if (contrib_s) begin
      run_flag_r      <= 1'b1;
      run_count_r     <= (run_count_r == 16'hFFFF) ? run_count_r : run_count_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_palette_mapper.sv
// Self-checking bench for palette_mapper: directed scenarios plus randomized traffic
// checked against a frame-level behavioural model.
module tb_palette_mapper;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  is_ball;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank_n;
  logic [1:0]  mode;
  logic        pal_we;
  logic [2:0]  pal_addr;
  logic [23:0] pal_data;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        collision_last;
  logic [15:0] collision_count;

  int checks = 0;
  int errors = 0;

  // Model state: palette, the pixel waiting in the pipeline, expected outputs.
  logic [23:0] m_pal [4];
  logic [3:0]  p_ball;
  logic        p_blank;
  logic [9:0]  p_x;
  logic [9:0]  p_y;
  logic [1:0]  p_mode;
  logic [23:0] m_rgb;
  logic        m_last;
  logic [15:0] m_cnt;
  logic        m_run_flag;
  int          m_run_cnt;

  palette_mapper dut (
    .Clk(Clk), .Reset_n(Reset_n), .is_ball(is_ball), .DrawX(DrawX), .DrawY(DrawY),
    .blank_n(blank_n), .mode(mode), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .collision_last(collision_last), .collision_count(collision_count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] ref_color(input logic [3:0] b, input logic bl, input logic [1:0] md);
    int r, g, bb, lo;
    if (!bl) return 24'h000000;
    if (b == 4'd0) return 24'h000000;
    lo = 0;
    while (!b[lo]) lo++;
    if (md == 2'd1 && $countones(b) >= 2) return 24'hFFFFFF;
    if (md != 2'd2) return m_pal[lo];
    r = 0; g = 0; bb = 0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        r  += int'(m_pal[i][23:16]);
        g  += int'(m_pal[i][15:8]);
        bb += int'(m_pal[i][7:0]);
      end
    end
    if (r > 255) r = 255;
    if (g > 255) g = 255;
    if (bb > 255) bb = 255;
    return {r[7:0], g[7:0], bb[7:0]};
  endfunction

  task automatic model_reset();
    m_pal[0] = 24'hFF9999; m_pal[1] = 24'h99FF99; m_pal[2] = 24'hCCFFFF; m_pal[3] = 24'hFFFF99;
    p_ball = 4'd0; p_blank = 1'b0; p_x = 10'd0; p_y = 10'd0; p_mode = 2'd0;
    m_rgb = 24'd0; m_last = 1'b0; m_cnt = 16'd0; m_run_flag = 1'b0; m_run_cnt = 0;
  endtask

  // One clock edge: advance the model with the inputs currently applied, then sample #1 later.
  task automatic tick();
    logic [23:0] nrgb;
    bit contrib;
    if (!Reset_n) begin
      model_reset();
    end else begin
      nrgb = ref_color(p_ball, p_blank, p_mode);
      contrib = p_blank && ($countones(p_ball) >= 2);
      if (p_x == 10'd0 && p_y == 10'd0) begin
        m_last = m_run_flag;
        m_cnt = m_run_cnt[15:0];
        m_run_flag = contrib;
        m_run_cnt = contrib ? 1 : 0;
      end else if (contrib) begin
        m_run_flag = 1'b1;
        if (m_run_cnt < 65535) m_run_cnt++;
      end
      if (pal_we && pal_addr < 3'd4) m_pal[pal_addr[1:0]] = pal_data;
      p_ball = is_ball; p_blank = blank_n; p_x = DrawX; p_y = DrawY; p_mode = mode;
      m_rgb = nrgb;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic set_px(input logic [3:0] b, input logic bl, input int x, input int y, input logic [1:0] md);
    is_ball = b; blank_n = bl; DrawX = 10'(x); DrawY = 10'(y); mode = md;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; pal_we = 1'b0; pal_addr = 3'd0; pal_data = 24'd0;
    set_px(4'b1111, 1'b1, 0, 0, 2'd1);
    tick(); tick();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000 || collision_last !== 1'b0 || collision_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: rgb=%h last=%b cnt=%0d, required 000000 0 0",
               {VGA_R, VGA_G, VGA_B}, collision_last, collision_count);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_solid();
    set_px(4'b0010, 1'b1, 5, 5, 2'd0);
    tick(); tick();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h99FF99) begin
      errors++; $display("FAIL solid_ball1: rgb=%h required 99ff99", {VGA_R, VGA_G, VGA_B});
    end
    set_px(4'b0000, 1'b1, 6, 5, 2'd0);
    tick(); tick();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
      errors++; $display("FAIL solid_bg: rgb=%h required 000000", {VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_overlap();
    logic [23:0] exp_tab [4];
    exp_tab[0] = 24'hFF9999; exp_tab[1] = 24'hFFFFFF; exp_tab[2] = 24'hFFFFFF; exp_tab[3] = 24'hFF9999;
    foreach (exp_tab[m]) begin
      set_px(4'b0101, 1'b1, 7, 5, 2'(m));
      tick(); tick();
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== exp_tab[m]) begin
        errors++; $display("FAIL overlap_mode%0d: rgb=%h required %h", m, {VGA_R, VGA_G, VGA_B}, exp_tab[m]);
      end
    end
  endtask

  task automatic test_palette();
    logic [23:0] want [4];
    set_px(4'b0100, 1'b1, 9, 5, 2'd0);
    tick(); tick();
    pal_we = 1'b1; pal_addr = 3'd2; pal_data = 24'h123456;
    tick();
    pal_we = 1'b0;
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hCCFFFF) begin
      errors++; $display("FAIL pal_write_cycle: rgb=%h required ccffff", {VGA_R, VGA_G, VGA_B});
    end
    tick();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h123456) begin
      errors++; $display("FAIL pal_next_cycle: rgb=%h required 123456", {VGA_R, VGA_G, VGA_B});
    end
    pal_we = 1'b1; pal_addr = 3'd5; pal_data = 24'hABCDEF;
    tick();
    pal_we = 1'b0;
    want[0] = 24'hFF9999; want[1] = 24'h99FF99; want[2] = 24'h123456; want[3] = 24'hFFFF99;
    for (int i = 0; i < 4; i++) begin
      set_px(4'(1 << i), 1'b1, 10 + i, 5, 2'd0);
      tick(); tick();
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== want[i]) begin
        errors++; $display("FAIL pal_entry%0d: rgb=%h required %h", i, {VGA_R, VGA_G, VGA_B}, want[i]);
      end
    end
  endtask

  task automatic test_collision();
    set_px(4'b0001, 1'b1, 0, 0, 2'd0); tick();
    for (int k = 1; k <= 7; k++) begin
      set_px(4'b0011, 1'b1, k, 0, 2'd0); tick();
    end
    set_px(4'b1111, 1'b0, 8, 0, 2'd0); tick();
    set_px(4'b0100, 1'b1, 9, 0, 2'd0); tick();
    set_px(4'b0001, 1'b1, 0, 0, 2'd0); tick(); tick();
    checks++;
    if (collision_last !== 1'b1 || collision_count !== 16'd7) begin
      errors++; $display("FAIL collision_7: last=%b cnt=%0d required 1 7", collision_last, collision_count);
    end
    for (int k = 1; k <= 3; k++) begin
      set_px(4'b0010, 1'b1, k, 1, 2'd0); tick();
    end
    set_px(4'b0001, 1'b1, 0, 0, 2'd0); tick(); tick();
    checks++;
    if (collision_last !== 1'b0 || collision_count !== 16'd0) begin
      errors++; $display("FAIL collision_none: last=%b cnt=%0d required 0 0", collision_last, collision_count);
    end
  endtask

  task automatic test_blank();
    set_px(4'b0001, 1'b1, 0, 0, 2'd0); tick();
    set_px(4'b1111, 1'b0, 3, 4, 2'd2); tick(); tick();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
      errors++; $display("FAIL blank_rgb: rgb=%h required 000000", {VGA_R, VGA_G, VGA_B});
    end
    set_px(4'b0001, 1'b1, 0, 0, 2'd0); tick(); tick();
    checks++;
    if (collision_last !== 1'b0 || collision_count !== 16'd0) begin
      errors++; $display("FAIL blank_nocount: last=%b cnt=%0d required 0 0", collision_last, collision_count);
    end
    set_px(4'b0110, 1'b1, 1, 0, 2'd0); tick();
    set_px(4'b1111, 1'b0, 0, 0, 2'd0); tick(); tick();
    checks++;
    if (collision_last !== 1'b1 || collision_count !== 16'd1) begin
      errors++; $display("FAIL blank_boundary: last=%b cnt=%0d required 1 1", collision_last, collision_count);
    end
    set_px(4'b0001, 1'b1, 2, 0, 2'd0); tick();
    set_px(4'b0001, 1'b1, 0, 0, 2'd0); tick(); tick();
    checks++;
    if (collision_last !== 1'b0 || collision_count !== 16'd0) begin
      errors++; $display("FAIL blank_origin_nocount: last=%b cnt=%0d required 0 0", collision_last, collision_count);
    end
  endtask

  task automatic test_reset_mid();
    set_px(4'b0011, 1'b1, 4, 2, 2'd1); tick(); tick();
    Reset_n = 1'b0; tick();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000 || collision_last !== 1'b0 || collision_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid: rgb=%h last=%b cnt=%0d required 000000 0 0",
                         {VGA_R, VGA_G, VGA_B}, collision_last, collision_count);
    end
    Reset_n = 1'b1;
    set_px(4'b0100, 1'b1, 4, 2, 2'd0); tick();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
      errors++; $display("FAIL reset_flush: rgb=%h required 000000", {VGA_R, VGA_G, VGA_B});
    end
    tick();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hCCFFFF) begin
      errors++; $display("FAIL reset_pal_default: rgb=%h required ccffff", {VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      Reset_n  = ($urandom_range(0, 63) != 0);
      is_ball  = 4'($urandom);
      blank_n  = ($urandom_range(0, 4) != 0);
      DrawX    = 10'($urandom_range(0, 2));
      DrawY    = 10'($urandom_range(0, 1));
      mode     = 2'($urandom);
      pal_we   = ($urandom_range(0, 7) == 0);
      pal_addr = 3'($urandom);
      pal_data = 24'($urandom);
      tick();
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== m_rgb || collision_last !== m_last || collision_count !== m_cnt) begin
        errors++;
        $display("FAIL random_%0d: rgb=%h last=%b cnt=%0d required %h %b %0d", n,
                 {VGA_R, VGA_G, VGA_B}, collision_last, collision_count, m_rgb, m_last, m_cnt);
      end
    end
    Reset_n = 1'b1; pal_we = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_solid();
    test_overlap();
    test_palette();
    test_collision();
    test_blank();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/palette_mapper.md
PALETTE_MAPPER -- requirements
Module: palette_mapper

Interface
REQ-001 SHALL: parameter NUM_BALLS, default 4, number of ball channels (range 2..8).
REQ-002 SHALL: parameter COLOR_W, default 8, bits per VGA colour channel.
REQ-003 SHALL: parameter BG_COLOR, default 24'h000000, background {R,G,B} when no ball hits.
REQ-004 SHALL: port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL: port Reset_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL: port is_ball, input, NUM_BALLS, per-ball hit for current pixel; bit i = ball i.
REQ-007 SHALL: port DrawX, input, 10, current pixel column.
REQ-008 SHALL: port DrawY, input, 10, current pixel row.
REQ-009 SHALL: port blank_n, input, 1, low = blanking interval.
REQ-010 SHALL: port mode, input, 2, colour mode (0 solid, 1 overlap-highlight, 2 additive, 3 = mode 0).
REQ-011 SHALL: port pal_we, input, 1, palette write strobe.
REQ-012 SHALL: port pal_addr, input, 3, palette entry index.
REQ-013 SHALL: port pal_data, input, 3*COLOR_W, write data {R,G,B}.
REQ-014 SHALL: ports VGA_R, VGA_G, VGA_B, output, COLOR_W each, registered pixel colour.
REQ-015 SHALL: port collision_last, output, 1, any overlap pixel in previous complete frame.
REQ-016 SHALL: port collision_count, output, 16, overlap-pixel count of previous frame, saturating at 16'hFFFF.

Function
REQ-017 SHALL: two-stage pipeline; inputs sampled at edge N drive VGA_R/G/B after edge N+1 (latency 2 cycles, throughput 1 pixel/cycle).
REQ-018 SHALL: stage 1 registers is_ball, blank_n, DrawX, DrawY, mode, plus hit = OR(is_ball), id = lowest set bit index, multi = popcount(is_ball) >= 2.
REQ-019 SHALL: stage 2 colour rules -- blank low: all 0; no hit: BG_COLOR; mode 0/3: palette[id]; mode 1: multi ? all-ones : palette[id]; mode 2: per channel sum of palette entries of all hit balls, saturating at all-ones.
REQ-020 SHALL: palette is NUM_BALLS x 3*COLOR_W registers; pal_we with pal_addr < NUM_BALLS updates entry at that edge; pal_addr >= NUM_BALLS ignored.
REQ-021 SHALL: stage-2 lookup in the write cycle returns the old entry; new value used from the next cycle.
REQ-022 SHALL: frame boundary = stage-2 pixel with DrawX==0 and DrawY==0; at that edge collision_last <= running flag, collision_count <= running count, running values restart counting this pixel.
REQ-023 SHALL: running flag/count increment only for stage-2 pixels with multi=1 and blank_n=1; count saturates at 16'hFFFF.
REQ-024 SHALL: blanked (0,0) pixel still triggers frame boundary but contributes no count.
REQ-025 SHALL: mode changes take effect for pixels sampled at the same edge as the change (mode travels with pixel).

Reset
REQ-026 SHALL: Reset_n low at an edge clears pipeline registers (hit=0, blank_n=0), VGA_R/G/B=0, collision_last=0, collision_count=0, running flag/count=0.
REQ-027 SHALL: reset loads palette entries 0..3 with FF9999, 99FF99, CCFFFF, FFFF99 (COLOR_W=8) and entries >=4 with all-ones.
REQ-028 SHALL: reset mid-frame discards in-flight pixels; first valid output 2 cycles after Reset_n returns high.

Verification
REQ-029 SHALL: after reset, is_ball=4'b0010, blank_n=1, mode=0 -> two edges later RGB=99,FF,99; is_ball=0 -> 00,00,00.
REQ-030 SHALL: is_ball=4'b0101, mode=1 -> FF,FF,FF; mode=0 -> FF,99,99; mode=2 -> FF,FF,FF (saturated sum).
REQ-031 SHALL: pal_we=1, pal_addr=2, pal_data=123456 with is_ball=4'b0100 held -> first stage-2 pixel in write cycle shows CC,FF,FF, next shows 12,34,56; pal_addr=5 (NUM_BALLS=4) -> palette unchanged.
REQ-032 SHALL: frame with exactly 7 unblanked overlap pixels, then stage-2 (0,0) -> collision_last=1, collision_count=7; next frame without overlap -> 0 and 0.
REQ-033 SHALL: blank_n=0 with is_ball=4'b1111 -> RGB 0, no count increment; Reset_n low mid-stream -> outputs 0 on next edge, palette back to defaults.
